// File: rtl/sfft_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// sfft_pingpong_buffer
//
// Double-buffered (ping-pong) complex sample store placed between SFFT
// pipeline stages. The producer fills the current write bank through two
// write ports while the consumer drains the other bank through two read
// ports. A bank becomes FULL on wr_commit and EMPTY again on rd_release, so
// neither side has to wait for the other except when both banks are FULL
// or both are EMPTY. Each committed bank carries a frame tag to the reader.
//
// Ports
//   clk, reset_n                  clock (posedge), asynchronous active-low reset
//   wr_ready                      write bank is EMPTY; writes and commit accepted
//   wr_en_a/b, wr_addr_a/b        write strobes and addresses (B wins on same address)
//   wr_real_a/b, wr_imag_a/b      write data
//   wr_commit, wr_tag             close the write bank and attach a frame tag
//   rd_valid, rd_tag              read bank is FULL; its tag (0 when not valid)
//   rd_en_a/b, rd_addr_a/b        read strobes and addresses
//   rd_real_a/b, rd_imag_a/b      read data, one cycle after rd_en
//   rd_dvalid_a/b                 read data valid
//   rd_release                    hand the read bank back to the writer
//   banks_full                    number of FULL banks (0..2)
//   wr_err, rd_err                sticky protocol-violation flags
// ---------------------------------------------------------------------------
module sfft_pingpong_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // write side
  output logic                  wr_ready,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [DATA_WIDTH-1:0] wr_real_a,
  input  logic [DATA_WIDTH-1:0] wr_imag_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [DATA_WIDTH-1:0] wr_real_b,
  input  logic [DATA_WIDTH-1:0] wr_imag_b,
  input  logic                  wr_commit,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  // read side
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_real_a,
  output logic [DATA_WIDTH-1:0] rd_imag_a,
  output logic                  rd_dvalid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_real_b,
  output logic [DATA_WIDTH-1:0] rd_imag_b,
  output logic                  rd_dvalid_b,
  input  logic                  rd_release,
  // status
  output logic [1:0]            banks_full,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int WORD_W = 2 * DATA_WIDTH;

  // Both banks live in one array; the bank pointer is the address MSB.
  logic [WORD_W-1:0]     r_mem [2*DEPTH];

  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_wr_err;
  logic                  r_rd_err;

  logic [1:0]            w_full;
  logic [TAG_WIDTH-1:0]  w_bank_tag [2];

  logic                  w_commit;
  logic                  w_release;
  logic                  w_wr_ok_a;
  logic                  w_wr_ok_b;

  logic [1:0]            w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr [2];
  logic [WORD_W-1:0]     w_rd_data [2];
  logic [1:0]            w_rd_dvalid;

  // Handshake status is derived straight from the bank state registers.
  assign wr_ready   = ~w_full[r_wr_bank];
  assign rd_valid   = w_full[r_rd_bank];
  assign rd_tag     = rd_valid ? w_bank_tag[r_rd_bank] : '0;
  assign banks_full = {1'b0, w_full[0]} + {1'b0, w_full[1]};
  assign wr_err     = r_wr_err;
  assign rd_err     = r_rd_err;

  assign w_commit   = wr_commit & wr_ready;
  assign w_release  = rd_release & rd_valid;
  assign w_wr_ok_a  = wr_en_a & wr_ready;
  assign w_wr_ok_b  = wr_en_b & wr_ready;

  // ---------------------------------------------------------------------------
  // Per-bank EMPTY/FULL state and frame tag. A commit only ever targets an
  // EMPTY bank and a release only a FULL one, so the two never collide on the
  // same bank even when they happen in the same cycle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic                 r_full;
      logic [TAG_WIDTH-1:0] r_tag;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_full <= 1'b0;
          r_tag  <= '0;
        end else if (w_commit && (r_wr_bank == 1'(gi))) begin
          r_full <= 1'b1;
          r_tag  <= wr_tag;
        end else if (w_release && (r_rd_bank == 1'(gi))) begin
          r_full <= 1'b0;
        end
      end

      assign w_full[gi]     = r_full;
      assign w_bank_tag[gi] = r_tag;
    end
  endgenerate

  // Bank pointers and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_err  <= 1'b0;
      r_rd_err  <= 1'b0;
    end else begin
      if (w_commit)
        r_wr_bank <= ~r_wr_bank;
      if (w_release)
        r_rd_bank <= ~r_rd_bank;
      if (!wr_ready && (wr_en_a || wr_en_b || wr_commit))
        r_wr_err <= 1'b1;
      if (!rd_valid && (rd_en_a || rd_en_b || rd_release))
        r_rd_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample storage (not reset). Port B is written last so it wins when both
  // ports hit the same address in the same cycle. Writes during the commit
  // cycle still use the old write pointer and so land in the committed bank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_ok_a)
      r_mem[{r_wr_bank, wr_addr_a}] <= {wr_real_a, wr_imag_a};
    if (w_wr_ok_b)
      r_mem[{r_wr_bank, wr_addr_b}] <= {wr_real_b, wr_imag_b};
  end

  // ---------------------------------------------------------------------------
  // Registered read ports. Reads in the release cycle use the old read
  // pointer, so they still return the bank being released. Data holds when
  // no read is accepted.
  // ---------------------------------------------------------------------------
  assign w_rd_en      = {rd_en_b, rd_en_a};
  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [WORD_W-1:0] r_data;
      logic              r_dvalid;
      logic              w_rd_ok;

      assign w_rd_ok = w_rd_en[gi] & rd_valid;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_data   <= '0;
          r_dvalid <= 1'b0;
        end else begin
          r_dvalid <= w_rd_ok;
          if (w_rd_ok)
            r_data <= r_mem[{r_rd_bank, w_rd_addr[gi]}];
        end
      end

      assign w_rd_data[gi]   = r_data;
      assign w_rd_dvalid[gi] = r_dvalid;
    end
  endgenerate

  assign {rd_real_a, rd_imag_a} = w_rd_data[0];
  assign {rd_real_b, rd_imag_b} = w_rd_data[1];
  assign rd_dvalid_a            = w_rd_dvalid[0];
  assign rd_dvalid_b            = w_rd_dvalid[1];

endmodule
